// File: rtl/ex_stage_ctrl_pkg.sv
// Shared encodings for the execute stage: ALU state/sign codes, branch
// conditions, instruction kinds and the sequencer FSM states.
package ex_stage_ctrl_pkg;

    // ex_stage_state codes presented to the ALU
    localparam logic [2:0] EXS_NOP    = 3'd0;
    localparam logic [2:0] BINARYEXPR = 3'd1;
    localparam logic [2:0] UNARYEXPR  = 3'd2;
    localparam logic [2:0] BRANCHCOND = 3'd3;
    localparam logic [2:0] MEMADDR    = 3'd4;

    // ALU sign-bit codes
    localparam logic [1:0] POS  = 2'd0;
    localparam logic [1:0] ZERO = 2'd1;
    localparam logic [1:0] NEG  = 2'd2;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    // Branch conditions
    localparam logic [1:0] BR_EQ = 2'd0;
    localparam logic [1:0] BR_NE = 2'd1;
    localparam logic [1:0] BR_LT = 2'd2;
    localparam logic [1:0] BR_GE = 2'd3;

    // Instruction kinds
    localparam logic [1:0] KIND_NORMAL = 2'd0;
    localparam logic [1:0] KIND_BRANCH = 2'd1;
    localparam logic [1:0] KIND_JAL    = 2'd2;
    localparam logic [1:0] KIND_JALR   = 2'd3;

    // Sequencer FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Control fields carried alongside the operands while executing
    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] bcond;
    } ex_ctrl_t;

    // Jumps always redirect; branches only when their condition holds
    function automatic logic redirects(input logic [1:0] kind, input logic taken);
        logic r;
        r = 1'b0;
        case (kind)
            KIND_BRANCH: r = taken;
            KIND_JAL:    r = 1'b1;
            KIND_JALR:   r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_ctrl_if.sv
// Bundle of the decode handshake, ALU operand/result bus and the
// memory/writeback handshake around the execute stage.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid may not depend on ready, and the offered payload must stay
// stable while valid is high and ready is low.
interface ex_stage_ctrl_if #(
    parameter int LEN  = 32,
    parameter int RD_W = 5
);
    // decode -> execute
    logic            in_valid;
    logic            in_ready;
    logic [LEN-1:0]  in_pc;
    logic [LEN-1:0]  in_rs1;
    logic [LEN-1:0]  in_rs2;
    logic [LEN-1:0]  in_imm;
    logic [2:0]      in_state;
    logic [3:0]      in_opcode;
    logic [1:0]      in_kind;
    logic [1:0]      in_bcond;
    logic [RD_W-1:0] in_rd;

    // execute <-> ALU
    logic [LEN-1:0]  alu_rs1;
    logic [LEN-1:0]  alu_rs2;
    logic [LEN-1:0]  alu_imm;
    logic [LEN-1:0]  alu_pc;
    logic [2:0]      alu_state;
    logic [3:0]      alu_opcode;
    logic [LEN-1:0]  alu_result;
    logic [1:0]      alu_sign_bits;

    // execute -> memory/writeback and fetch
    logic            out_valid;
    logic            out_ready;
    logic [LEN-1:0]  out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_wb_en;
    logic            redirect_valid;
    logic [LEN-1:0]  redirect_pc;

    // The execute stage itself
    modport master (
        input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_state, in_opcode,
               in_kind, in_bcond, in_rd, alu_result, alu_sign_bits, out_ready,
        output in_ready, alu_rs1, alu_rs2, alu_imm, alu_pc, alu_state,
               alu_opcode, out_valid, out_result, out_rd, out_wb_en,
               redirect_valid, redirect_pc
    );

    // The surrounding decode, ALU and downstream logic
    modport slave (
        output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_state, in_opcode,
               in_kind, in_bcond, in_rd, alu_result, alu_sign_bits, out_ready,
        input  in_ready, alu_rs1, alu_rs2, alu_imm, alu_pc, alu_state,
               alu_opcode, out_valid, out_result, out_rd, out_wb_en,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_stage_ctrl_branch_cond_unit.sv
// Combinational branch condition evaluation from the ALU sign bits of rs1-rs2.
module branch_cond_unit
    import ex_stage_ctrl_pkg::*;
(
    input  logic [1:0] bcond,
    input  logic [1:0] sign_bits,
    output logic       taken
);

    // Map the branch condition onto the sign of rs1-rs2
    always_comb begin
        taken = 1'b0;
        case (bcond)
            BR_EQ: taken = (sign_bits == ZERO);
            BR_NE: taken = (sign_bits != ZERO);
            BR_LT: taken = (sign_bits == NEG);
            BR_GE: taken = (sign_bits == POS) || (sign_bits == ZERO);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage_ctrl.sv
// Execute-stage sequencer: registers decoded operands onto the ALU inputs,
// captures the result one cycle later, resolves branches/jumps into a single
// cycle redirect pulse and holds the result for memory/writeback.
module ex_stage_ctrl
    import ex_stage_ctrl_pkg::*;
#(
    parameter int LEN  = 32,
    parameter int RD_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy_in,
    input  logic           flush,
    ex_stage_ctrl_if.master bus,
    output logic [1:0]     dbg_state
);

    logic [1:0]      state;
    ex_ctrl_t        ctrl_q;
    logic [RD_W-1:0] rd_q;

    logic [LEN-1:0]  alu_rs1_q;
    logic [LEN-1:0]  alu_rs2_q;
    logic [LEN-1:0]  alu_imm_q;
    logic [LEN-1:0]  alu_pc_q;
    logic [2:0]      alu_state_q;
    logic [3:0]      alu_opcode_q;

    logic [LEN-1:0]  out_result_q;
    logic [RD_W-1:0] out_rd_q;
    logic            out_wb_en_q;
    logic            redir_valid_q;
    logic [LEN-1:0]  redir_pc_q;

    logic            accept;
    logic            taken;
    logic            is_jump;
    logic [LEN-1:0]  link_pc;
    logic [LEN-1:0]  br_target;
    logic [LEN-1:0]  jump_target;
    logic [LEN-1:0]  exec_result;

    branch_cond_unit u_branch_cond_unit (
        .bcond     (ctrl_q.bcond),
        .sign_bits (bus.alu_sign_bits),
        .taken     (taken)
    );

    // Handshake, resolution arithmetic and output wiring
    always_comb begin
        bus.in_ready = rdy_in & ((state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready)) & ~flush;
        accept       = bus.in_valid & bus.in_ready;
        is_jump      = (ctrl_q.kind == KIND_JAL) || (ctrl_q.kind == KIND_JALR);
        link_pc      = alu_pc_q + LEN'(4);
        br_target    = alu_pc_q + {alu_imm_q[LEN-2:0], 1'b0};
        jump_target  = (ctrl_q.kind == KIND_JALR) ? (bus.alu_result & ~LEN'(1)) : br_target;
        exec_result  = is_jump ? link_pc : bus.alu_result;

        bus.alu_rs1        = alu_rs1_q;
        bus.alu_rs2        = alu_rs2_q;
        bus.alu_imm        = alu_imm_q;
        bus.alu_pc         = alu_pc_q;
        bus.alu_state      = alu_state_q;
        bus.alu_opcode     = alu_opcode_q;
        bus.out_valid      = (state == ST_DONE);
        bus.out_result     = out_result_q;
        bus.out_rd         = out_rd_q;
        bus.out_wb_en      = out_wb_en_q;
        bus.redirect_valid = redir_valid_q;
        bus.redirect_pc    = redir_pc_q;
        dbg_state          = state;
    end

    // Sequencer: IDLE -> EXEC -> DONE, frozen while rdy_in is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ctrl_q        <= '0;
            rd_q          <= '0;
            alu_rs1_q     <= '0;
            alu_rs2_q     <= '0;
            alu_imm_q     <= '0;
            alu_pc_q      <= '0;
            alu_state_q   <= '0;
            alu_opcode_q  <= '0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_wb_en_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else if (rdy_in) begin
            // The redirect is a pulse; only the EXEC->DONE edge raises it
            redir_valid_q <= 1'b0;

            // accept already excludes flush, so a squashed offer never latches
            if (accept) begin
                alu_rs1_q    <= bus.in_rs1;
                alu_rs2_q    <= bus.in_rs2;
                alu_imm_q    <= bus.in_imm;
                alu_pc_q     <= bus.in_pc;
                alu_state_q  <= bus.in_state;
                alu_opcode_q <= bus.in_opcode;
                ctrl_q.kind  <= bus.in_kind;
                ctrl_q.bcond <= bus.in_bcond;
                rd_q         <= bus.in_rd;
            end

            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        out_result_q <= exec_result;
                        out_rd_q     <= rd_q;
                        out_wb_en_q  <= (rd_q != '0) && (ctrl_q.kind != KIND_BRANCH);
                        if (redirects(ctrl_q.kind, taken)) begin
                            redir_valid_q <= 1'b1;
                            redir_pc_q    <= jump_target;
                        end
                        state <= ST_DONE;
                    end
                    ST_DONE: begin
                        if (bus.out_ready) state <= bus.in_valid ? ST_EXEC : ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed bench for ex_stage_ctrl with a behavioural ALU stub, an output
// scoreboard and a redirect scoreboard.
module tb_ex_stage_ctrl;
    import ex_stage_ctrl_pkg::*;

    localparam int LEN  = 32;
    localparam int RD_W = 5;
    localparam int W    = LEN + RD_W + 1;

    logic clk;
    logic rst_n;
    logic rdy_in;
    logic flush;
    logic [1:0] dbg_state;

    ex_stage_ctrl_if #(.LEN(LEN), .RD_W(RD_W)) bus ();

    ex_stage_ctrl #(.LEN(LEN), .RD_W(RD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   exp_q[$];
    logic [LEN-1:0] redir_q[$];

    logic [W-1:0]   pend_exp;
    logic           pend_push;
    logic           pend_redir;
    logic [LEN-1:0] pend_rpc;

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU stub: branch compare, address add, add/sub
    always_comb begin
        bus.alu_result    = '0;
        bus.alu_sign_bits = POS;
        case (bus.alu_state)
            BRANCHCOND: begin
                bus.alu_result = bus.alu_rs1 - bus.alu_rs2;
                if ($signed(bus.alu_rs1) < $signed(bus.alu_rs2)) bus.alu_sign_bits = NEG;
                else if (bus.alu_rs1 == bus.alu_rs2)             bus.alu_sign_bits = ZERO;
                else                                             bus.alu_sign_bits = POS;
            end
            MEMADDR: bus.alu_result = bus.alu_rs1 + bus.alu_imm;
            default: begin
                bus.alu_result = (bus.alu_opcode == ALU_SUB) ? bus.alu_rs1 - bus.alu_rs2
                                                             : bus.alu_rs1 + bus.alu_rs2;
            end
        endcase
        if (bus.alu_state != BRANCHCOND) begin
            if (bus.alu_result == '0)         bus.alu_sign_bits = ZERO;
            else if (bus.alu_result[LEN-1])   bus.alu_sign_bits = NEG;
            else                              bus.alu_sign_bits = POS;
        end
    end

    // scoreboard monitor: output handshakes and redirect pulses
    always @(negedge clk) begin
        logic [W-1:0]   e;
        logic [LEN-1:0] r;
        if (rst_n && rdy_in && !flush && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got res=%h rd=%0d wb=%0b, nothing expected",
                         bus.out_result, bus.out_rd, bus.out_wb_en);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_result, bus.out_rd, bus.out_wb_en} !== e) begin
                    errors++;
                    $display("FAIL out_check: got res=%h rd=%0d wb=%0b want res=%h rd=%0d wb=%0b",
                             bus.out_result, bus.out_rd, bus.out_wb_en,
                             e[W-1 -: LEN], e[RD_W:1], e[0]);
                end
            end
        end
        if (rst_n && bus.redirect_valid) begin
            checks++;
            if (redir_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc=%h, no redirect expected", bus.redirect_pc);
            end else begin
                r = redir_q.pop_front();
                if (bus.redirect_pc !== r) begin
                    errors++;
                    $display("FAIL redirect_pc: got %h want %h", bus.redirect_pc, r);
                end
            end
        end
    end

    task automatic check(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // driver: place an instruction on the decode bus
    task automatic present(input logic [LEN-1:0] pc, input logic [LEN-1:0] rs1,
                           input logic [LEN-1:0] rs2, input logic [LEN-1:0] imm,
                           input logic [2:0] st, input logic [3:0] op,
                           input logic [1:0] kind, input logic [1:0] bcond,
                           input logic [RD_W-1:0] rd, input logic push,
                           input logic [LEN-1:0] e_res, input logic e_wb,
                           input logic e_redir, input logic [LEN-1:0] e_rpc);
        bus.in_pc     = pc;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_state  = st;
        bus.in_opcode = op;
        bus.in_kind   = kind;
        bus.in_bcond  = bcond;
        bus.in_rd     = rd;
        bus.in_valid  = 1'b1;
        pend_push     = push;
        pend_exp      = {e_res, rd, e_wb};
        pend_redir    = e_redir;
        pend_rpc      = e_rpc;
    endtask

    // driver: wait for the handshake; call just after a rising edge
    task automatic accept();
        int n;
        n = 0;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b want 1", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            if (pend_push) begin
                exp_q.push_back(pend_exp);
                if (pend_redir) redir_q.push_back(pend_rpc);
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [LEN-1:0] pc, input logic [LEN-1:0] rs1,
                        input logic [LEN-1:0] rs2, input logic [LEN-1:0] imm,
                        input logic [2:0] st, input logic [3:0] op,
                        input logic [1:0] kind, input logic [1:0] bcond,
                        input logic [RD_W-1:0] rd, input logic push,
                        input logic [LEN-1:0] e_res, input logic e_wb,
                        input logic e_redir, input logic [LEN-1:0] e_rpc);
        present(pc, rs1, rs2, imm, st, op, kind, bcond, rd, push, e_res, e_wb, e_redir, e_rpc);
        accept();
    endtask

    // wait for both scoreboards to empty, bounded
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || redir_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || redir_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending out=%0d redirect=%0d want 0 0",
                     exp_q.size(), redir_q.size());
            exp_q.delete();
            redir_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [LEN-1:0] held;

        rst_n         = 1'b0;
        rdy_in        = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.in_state  = '0;
        bus.in_opcode = '0;
        bus.in_kind   = '0;
        bus.in_bcond  = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b1;
        pend_exp      = '0;
        pend_push     = 1'b0;
        pend_redir    = 1'b0;
        pend_rpc      = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", LEN'(dbg_state), LEN'(ST_IDLE));
        check("rst_out_valid", LEN'(bus.out_valid), 0);
        check("rst_redirect_valid", LEN'(bus.redirect_valid), 0);
        check("rst_alu_state", LEN'(bus.alu_state), 0);
        check("rst_alu_rs1", bus.alu_rs1, 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("idle_in_ready", LEN'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // ADD 5+7 -> rd3, with latency checks
        send(32'h10, 32'd5, 32'd7, 32'd0, BINARYEXPR, ALU_ADD, KIND_NORMAL, BR_EQ, 5'd3,
             1'b1, 32'd12, 1'b1, 1'b0, 32'd0);
        check("add_alu_state", LEN'(bus.alu_state), LEN'(BINARYEXPR));
        check("add_alu_rs1", bus.alu_rs1, 32'd5);
        check("add_exec_out_valid", LEN'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check("add_latency_out_valid", LEN'(bus.out_valid), 1);
        drain();

        // BEQ taken: 0x100 + 8*2
        send(32'h100, 32'd9, 32'd9, 32'd8, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_EQ, 5'd5,
             1'b1, 32'd0, 1'b0, 1'b1, 32'h110);
        drain();
        // BLT not taken: 4 > 2
        send(32'h120, 32'd4, 32'd2, 32'd8, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_LT, 5'd0,
             1'b1, 32'd2, 1'b0, 1'b0, 32'd0);
        drain();
        // BLT taken: -5 < 3, 0x500 + 0x40
        send(32'h500, 32'hFFFF_FFFB, 32'd3, 32'h20, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_LT, 5'd0,
             1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h540);
        drain();
        // BNE not taken: equal operands
        send(32'h600, 32'd1, 32'd1, 32'h20, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_NE, 5'd0,
             1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
        drain();
        // BGE taken with backward offset: 7 >= -1, 0x400 - 4 wraps to 0x3FC
        send(32'h400, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_GE, 5'd0,
             1'b1, 32'd8, 1'b0, 1'b1, 32'h3FC);
        drain();
        // JALR: (0x1001 + 4) & ~1, link 0x204
        send(32'h200, 32'h1001, 32'd0, 32'd4, MEMADDR, ALU_ADD, KIND_JALR, BR_EQ, 5'd1,
             1'b1, 32'h204, 1'b1, 1'b1, 32'h1004);
        drain();
        // JAL to x0: redirect but no writeback
        send(32'h700, 32'd0, 32'd0, 32'h10, EXS_NOP, ALU_ADD, KIND_JAL, BR_EQ, 5'd0,
             1'b1, 32'h704, 1'b0, 1'b1, 32'h720);
        drain();

        // back-to-back ADD then SUB
        send(32'h10, 32'd1, 32'd2, 32'd0, BINARYEXPR, ALU_ADD, KIND_NORMAL, BR_EQ, 5'd4,
             1'b1, 32'd3, 1'b1, 1'b0, 32'd0);
        send(32'h14, 32'd10, 32'd3, 32'd0, BINARYEXPR, ALU_SUB, KIND_NORMAL, BR_EQ, 5'd6,
             1'b1, 32'd7, 1'b1, 1'b0, 32'd0);
        drain();

        // backpressure: JAL held in DONE while the next ADD waits
        bus.out_ready = 1'b0;
        send(32'h300, 32'd0, 32'd0, 32'h10, EXS_NOP, ALU_ADD, KIND_JAL, BR_EQ, 5'd2,
             1'b1, 32'h304, 1'b1, 1'b1, 32'h320);
        @(posedge clk);
        #1;
        present(32'h308, 32'd20, 32'd22, 32'd0, BINARYEXPR, ALU_ADD, KIND_NORMAL, BR_EQ, 5'd7,
                1'b1, 32'd42, 1'b1, 1'b0, 32'd0);
        held = bus.out_result;
        check("bp_held_result", held, 32'h304);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", LEN'(bus.in_ready), 0);
            check("bp_out_valid", LEN'(bus.out_valid), 1);
            check("bp_out_result", bus.out_result, held);
            check("bp_state", LEN'(dbg_state), LEN'(ST_DONE));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        accept();
        check("bp_release_state", LEN'(dbg_state), LEN'(ST_EXEC));
        check("bp_release_alu_rs1", bus.alu_rs1, 32'd20);
        drain();

        // flush while executing a taken branch, with a new offer pending
        send(32'h800, 32'd3, 32'd3, 32'd4, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_EQ, 5'd0,
             1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        flush = 1'b1;
        present(32'h804, 32'd1, 32'd1, 32'd0, BINARYEXPR, ALU_ADD, KIND_NORMAL, BR_EQ, 5'd8,
                1'b0, 32'd2, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check("flush_in_ready", LEN'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_state", LEN'(dbg_state), LEN'(ST_IDLE));
        check("flush_out_valid", LEN'(bus.out_valid), 0);
        check("flush_redirect_valid", LEN'(bus.redirect_valid), 0);
        repeat (4) @(posedge clk);
        #1 check("flush_still_idle", LEN'(dbg_state), LEN'(ST_IDLE));

        // rdy_in low for two cycles mid-EXEC
        send(32'h900, 32'd100, 32'd23, 32'd0, BINARYEXPR, ALU_ADD, KIND_NORMAL, BR_EQ, 5'd9,
             1'b1, 32'd123, 1'b1, 1'b0, 32'd0);
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("frz_state", LEN'(dbg_state), LEN'(ST_EXEC));
            check("frz_out_valid", LEN'(bus.out_valid), 0);
            check("frz_in_ready", LEN'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 rdy_in = 1'b1;
        drain();

        // reset mid-EXEC drops the instruction and its redirect
        send(32'hA00, 32'd5, 32'd5, 32'd4, BRANCHCOND, ALU_SUB, KIND_BRANCH, BR_EQ, 5'd0,
             1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_exec_state", LEN'(dbg_state), LEN'(ST_IDLE));
        check("rst_exec_redirect", LEN'(bus.redirect_valid), 0);
        check("rst_exec_alu_rs1", bus.alu_rs1, 0);
        repeat (4) @(posedge clk);
        #1 check("rst_exec_idle", LEN'(dbg_state), LEN'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
